// File: rtl/sb_product_serializer_if.sv
// ---------------------------------------------------------------------------
// sb_product_serializer_if
//   Bundles the product-capture and word-output handshakes of the product
//   serializer.
//
//   Handshake rule (both channels): a transfer happens on a rising clk edge
//   where valid && ready. The sender holds valid and its payload stable
//   until that transfer. The receiver may raise or drop ready at any time.
//
//   Signals:
//     p_valid / p_ready / p_data : wide product channel (PW bits) into the block
//     w_valid / w_ready / w_data : narrow word channel (WW bits) out of the block
//     w_last                     : marks the final word of a product
//
//   Modports:
//     slave  : the serializer (product sink, word source)
//     master : the environment (product source, word sink)
// ---------------------------------------------------------------------------
interface sb_product_serializer_if #(
  parameter int PW = 512,
  parameter int WW = 32
) ();
  logic          p_valid;
  logic          p_ready;
  logic [PW-1:0] p_data;
  logic          w_valid;
  logic          w_ready;
  logic [WW-1:0] w_data;
  logic          w_last;

  modport slave (
    input  p_valid, p_data, w_ready,
    output p_ready, w_valid, w_data, w_last
  );

  modport master (
    output p_valid, p_data, w_ready,
    input  p_ready, w_valid, w_data, w_last
  );
endinterface

// File: rtl/sb_product_serializer.sv
// ---------------------------------------------------------------------------
// sb_product_serializer
//   Unload stage for the serial schoolbook multiplier. Captures one PW-bit
//   product and streams it as NW = PW/WW words of WW bits, least-significant
//   word first, honouring backpressure on the word channel.
//
//   Ports:
//     clk       : clock, rising edge
//     rst       : synchronous reset, active low
//     bus       : sb_product_serializer_if.slave (product in, words out)
//     busy      : a product is being streamed or is waiting in the hold buffer
//     ovf       : sticky; a product was offered while p_ready was low
//     dbg_state : current FSM state (0 = IDLE, 1 = SEND)
//
//   Build option:
//     SB_SER_DBUF_EN : adds a second PW-bit holding register so the next
//                      product can be taken while the current one streams,
//                      giving back-to-back output with no bubble.
//
//   PW must be a multiple of WW.
// ---------------------------------------------------------------------------
module sb_product_serializer #(
  parameter int PW = 512,
  parameter int WW = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  sb_product_serializer_if.slave bus,
  output logic                   busy,
  output logic                   ovf,
  output logic                   dbg_state
);

  localparam int NW = PW / WW;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NW-1:0][WW-1:0]  act_q, act_d;
  logic                   w_valid_q, w_valid_d;
  logic                   w_last_q, w_last_d;
  logic [WW-1:0]          w_data_q, w_data_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d;
`ifdef SB_SER_DBUF_EN
  logic [NW-1:0][WW-1:0]  hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
`endif

  logic p_ready;
  logic p_acc;
  logic w_acc;
  logic last_acc;

  // p_ready comes only from registered state, never from p_valid or w_ready.
`ifdef SB_SER_DBUF_EN
  assign p_ready = !hold_full_q;
`else
  assign p_ready = (state_q == IDLE);
`endif

  assign p_acc    = bus.p_valid && p_ready;
  assign w_acc    = w_valid_q && bus.w_ready;
  assign last_acc = w_acc && (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_d   = act_q;
    // An offer that cannot be taken is dropped and remembered until reset.
    ovf_d   = ovf_q | (bus.p_valid & ~p_ready);
`ifdef SB_SER_DBUF_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif

    case (state_q)
      IDLE: begin
        if (p_acc) begin
          act_d   = bus.p_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (w_acc) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + IW'(1);
          end else begin
`ifdef SB_SER_DBUF_EN
            if (hold_full_q) begin
              act_d       = hold_q;
              hold_full_d = 1'b0;
              idx_d       = '0;
            end else if (p_acc) begin
              // Product arriving on the final word bypasses the hold buffer.
              act_d = bus.p_data;
              idx_d = '0;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end
        end
`ifdef SB_SER_DBUF_EN
        if (p_acc && !last_acc) begin
          hold_d      = bus.p_data;
          hold_full_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state values so they line up
    // with state_q/idx_q in the following cycle.
    w_valid_d = (state_d == SEND);
    w_last_d  = (state_d == SEND) && (idx_d == LAST_IDX);
    w_data_d  = (state_d == SEND) ? act_d[idx_d] : '0;
`ifdef SB_SER_DBUF_EN
    busy_d    = (state_d == SEND) || hold_full_d;
`else
    busy_d    = (state_d == SEND);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      act_q       <= '0;
      w_valid_q   <= 1'b0;
      w_last_q    <= 1'b0;
      w_data_q    <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SB_SER_DBUF_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      act_q       <= act_d;
      w_valid_q   <= w_valid_d;
      w_last_q    <= w_last_d;
      w_data_q    <= w_data_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
`ifdef SB_SER_DBUF_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

  assign bus.p_ready = p_ready;
  assign bus.w_valid = w_valid_q;
  assign bus.w_data  = w_data_q;
  assign bus.w_last  = w_last_q;
  assign busy        = busy_q;
  assign ovf         = ovf_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sb_product_serializer.sv
// ---------------------------------------------------------------------------
// tb_sb_product_serializer
//   Self-checking bench for sb_product_serializer. Expected words are queued
//   when a product is driven and compared as the block emits them. A table of
//   product records covers the main streaming patterns; hand-written
//   sequences cover reset mid-stream and the double-buffer corner cases.
// ---------------------------------------------------------------------------
module tb_sb_product_serializer;

  localparam int PW = 512;
  localparam int WW = 32;
  localparam int NW = PW / WW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic busy, ovf, dbg_state;

  sb_product_serializer_if #(.PW(PW), .WW(WW)) bus ();

  sb_product_serializer #(.PW(PW), .WW(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [WW:0] exp_q[$];   // {w_last, w_data}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] word_fill(input logic [WW-1:0] base, input logic [WW-1:0] step);
    logic [PW-1:0] d;
    for (int i = 0; i < NW; i++) d[i*WW +: WW] = base + WW'(i) * step;
    return d;
  endfunction

  function automatic logic [PW-1:0] word_rand();
    logic [PW-1:0] d;
    for (int i = 0; i < NW; i++) d[i*WW +: WW] = WW'($urandom());
    return d;
  endfunction

  task automatic push_product(input logic [PW-1:0] d);
    for (int i = 0; i < NW; i++) exp_q.push_back({(i == NW - 1), d[i*WW +: WW]});
  endtask

  // Monitor: sampled mid-cycle, so w_ready set after the previous edge is
  // what the next edge will see.
  logic        stall_q = 1'b0;
  logic [WW:0] stall_v = '0;
  always @(negedge clk) begin
    if (!rst) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("stall w_valid", bus.w_valid, 1);
        check("stall w_data/w_last", {bus.w_last, bus.w_data}, stall_v);
      end
      if (bus.w_valid && bus.w_ready) begin
        if (exp_q.size() == 0) check("unexpected word", 1, 0);
        else check("word", {bus.w_last, bus.w_data}, exp_q.pop_front());
      end
      stall_q <= bus.w_valid && !bus.w_ready;
      stall_v <= {bus.w_last, bus.w_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int k = 0;
    while (!bus.p_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.p_ready) check("p_ready timeout", 0, 1);
  endtask

  // mode 0: w_ready always 1; mode 1: w_ready 1,0,1,0,...
  // inject_at >= 0 offers a junk product while that many words have gone.
  task automatic run_product(input string name, input logic [PW-1:0] d, input int mode,
                             input int inject_at, input int exp_cycles, input bit exp_ovf);
    int cycles = 0;
    int acc    = 0;
    bit phase  = 1'b0;
    bit done   = 1'b0;
    bit inj    = 1'b0;
    bit inj_now;
    wait_ready();
    push_product(d);
    bus.p_data  = d;
    bus.p_valid = 1'b1;
    bus.w_ready = 1'b1;
    @(posedge clk); #1;
    bus.p_valid = 1'b0;
    check({name, " first word latency"}, bus.w_valid, 1);
    while (!done && cycles < 200) begin
      inj_now     = 1'b0;
      bus.w_ready = (mode == 0) ? 1'b1 : !phase;
      if (acc == inject_at && !inj) begin
        inj         = 1'b1;
        inj_now     = 1'b1;
        bus.p_valid = 1'b1;
        bus.p_data  = ~d;
        check({name, " p_ready low in SEND"}, bus.p_ready, 0);
      end
      done = bus.w_valid && bus.w_ready && bus.w_last;
      if (bus.w_valid && bus.w_ready) acc++;
      @(posedge clk); #1;
      bus.p_valid = 1'b0;
      if (inj_now) check({name, " ovf set"}, ovf, 1);
      cycles++;
      phase = ~phase;
    end
    bus.w_ready = 1'b0;
    check({name, " cycles"}, cycles, exp_cycles);
    check({name, " w_valid after"}, bus.w_valid, 0);
    check({name, " busy after"}, busy, 0);
    check({name, " ovf"}, ovf, exp_ovf);
    check({name, " queue drained"}, exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [PW-1:0] data;
    int            mode;
    int            inject_at;
    int            exp_cycles;
    bit            exp_ovf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] pa, pb, pc;
    int gaps;

    vecs[0] = '{word_fill(32'h1000_0000, 32'd1), 0, -1, 16, 1'b0};
    vecs[1] = '{word_fill(32'h1000_0000, 32'd1), 1, -1, 31, 1'b0};
`ifdef SB_SER_DBUF_EN
    vecs[2] = '{word_fill(32'h1000_0000, 32'd1), 0, -1, 16, 1'b0};
    vecs[3] = '{word_rand(), 0, -1, 16, 1'b0};
    vecs[4] = '{word_rand(), 1, -1, 31, 1'b0};
`else
    // Overflow at word 5, then later products still stream; ovf stays set.
    vecs[2] = '{word_fill(32'h1000_0000, 32'd1), 0, 5, 16, 1'b1};
    vecs[3] = '{word_rand(), 0, -1, 16, 1'b1};
    vecs[4] = '{word_rand(), 1, -1, 31, 1'b1};
`endif

    bus.p_valid = 1'b0;
    bus.p_data  = '0;
    bus.w_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset w_valid", bus.w_valid, 0);
    check("reset w_data", bus.w_data, 0);
    check("reset w_last", bus.w_last, 0);
    check("reset ovf", ovf, 0);
    check("reset busy", busy, 0);
    check("reset p_ready", bus.p_ready, 1);
    check("reset state", dbg_state, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      run_product($sformatf("vec%0d", v), vecs[v].data, vecs[v].mode,
                  vecs[v].inject_at, vecs[v].exp_cycles, vecs[v].exp_ovf);
      @(posedge clk); #1;
    end

`ifdef SB_SER_DBUF_EN
    // A and B back to back, C offered while B is held.
    pa = word_fill(32'hAAAA_AAAA, 32'd0);
    pb = word_fill(32'hBBBB_BBBB, 32'd0);
    pc = word_fill(32'hCCCC_CCCC, 32'd0);
    wait_ready();
    push_product(pa);
    push_product(pb);
    bus.p_data  = pa;
    bus.p_valid = 1'b1;
    bus.w_ready = 1'b1;
    gaps = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 2 * NW; k++) begin
      if (!bus.w_valid) gaps++;
      if (k == 0) begin
        check("dbuf p_ready with hold empty", bus.p_ready, 1);
        bus.p_data = pb;
      end
      if (k == 1) begin
        check("dbuf ovf after B", ovf, 0);
        check("dbuf p_ready with hold full", bus.p_ready, 0);
        bus.p_data = pc;
      end
      if (k == 2) begin
        bus.p_valid = 1'b0;
        check("dbuf ovf after C", ovf, 1);
      end
      @(posedge clk); #1;
    end
    check("dbuf A/B gaps", gaps, 0);
    check("dbuf A/B w_valid after", bus.w_valid, 0);
    check("dbuf A/B busy after", busy, 0);
    check("dbuf A/B queue drained", exp_q.size(), 0);

    // Product offered exactly on the last word accept with hold empty.
    pa = word_fill(32'h1000_0000, 32'd1);
    pb = word_rand();
    wait_ready();
    push_product(pa);
    push_product(pb);
    bus.p_data  = pa;
    bus.p_valid = 1'b1;
    gaps = 0;
    @(posedge clk); #1;
    bus.p_valid = 1'b0;
    for (int k = 0; k < 2 * NW; k++) begin
      if (!bus.w_valid) gaps++;
      if (k == NW - 1) begin
        check("dbuf last-word w_last", bus.w_last, 1);
        check("dbuf last-word p_ready", bus.p_ready, 1);
        bus.p_data  = pb;
        bus.p_valid = 1'b1;
      end
      if (k == NW) begin
        bus.p_valid = 1'b0;
        check("dbuf bypass busy", busy, 1);
      end
      @(posedge clk); #1;
    end
    check("dbuf bypass gaps", gaps, 0);
    check("dbuf bypass w_valid after", bus.w_valid, 0);
    check("dbuf bypass queue drained", exp_q.size(), 0);
    bus.w_ready = 1'b0;
`endif

    // Reset at word 7 of a product.
    pa = word_fill(32'h1000_0000, 32'd1);
    wait_ready();
    push_product(pa);
    bus.p_data  = pa;
    bus.p_valid = 1'b1;
    bus.w_ready = 1'b1;
    @(posedge clk); #1;
    bus.p_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid-stream word 7", bus.w_data, 32'h1000_0007);
    rst         = 1'b0;
    bus.w_ready = 1'b0;
    @(posedge clk); #1;
    check("abort w_valid", bus.w_valid, 0);
    check("abort w_data", bus.w_data, 0);
    check("abort ovf", ovf, 0);
    check("abort p_ready", bus.p_ready, 1);
    check("abort busy", busy, 0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("post-reset state", dbg_state, 0);
    check("post-reset no words", bus.w_valid, 0);

    run_product("fresh after reset", word_fill(32'h1000_0000, 32'd1), 0, -1, 16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
